// File: rtl/c1541_pkg.sv
// c1541_pkg
//   Shared definitions for the 1541 drive read electronics.
//   - speed_zone_t : density zone 0..3 (zone 0 is the slowest bit rate)
//   - SYNC_BITS    : run of ones that counts as a SYNC mark
//   - cell_period(): bit-cell length in clk cycles for a zone
package c1541_pkg;

    typedef enum logic [1:0] {
        ZONE0 = 2'd0,
        ZONE1 = 2'd1,
        ZONE2 = 2'd2,
        ZONE3 = 2'd3
    } speed_zone_t;

    localparam int SYNC_BITS = 10;
    localparam int PHASE_W   = 7;

    // (16 - zone) * 8 clocks: 128 for zone 0 down to 104 for zone 3.
    // Eight bits wide because 128 does not fit in the phase counter.
    function automatic logic [7:0] cell_period(input speed_zone_t zone);
        logic [7:0] z;
        z = {6'd0, zone};
        return (8'd16 - z) << 3;
    endfunction

endpackage

// File: rtl/c1541_bit_clock.sv
// c1541_bit_clock
//   Data separator: tracks the bit-cell phase, latches flux transitions
//   and emits one strobe per bit cell.
//   Ports:
//     clk, rst         clock, async active-high reset
//     mtr_i            motor on; 0 freezes phase and pending bit
//     mode_i           1 = read; 0 ignores flux and yields zero bits
//     speed_zone_i     density zone selecting the cell period
//     flux_i           flux-change pulse, any width
//     bit_strobe_o     high for one cycle at each cell boundary
//     bit_value_o      bit recovered for the cell ending this cycle
module c1541_bit_clock
    import c1541_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       mtr_i,
    input  logic       mode_i,
    input  logic [1:0] speed_zone_i,
    input  logic       flux_i,
    output logic       bit_strobe_o,
    output logic       bit_value_o
);

    logic               flux_d_q;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               pending_q, pending_d;

    logic [7:0]         period;
    logic [PHASE_W-1:0] last;
    logic [PHASE_W-1:0] half;
    logic               flux_edge;
    logic               boundary;

    always_comb begin
        period = cell_period(speed_zone_t'(speed_zone_i));
        last   = PHASE_W'(period - 8'd1);
        half   = PHASE_W'(period >> 1);
    end

    assign flux_edge = flux_i & ~flux_d_q & mode_i;
    // >= rather than == so a zone change to a shorter cell never lets
    // the phase run past the end of the cell.
    assign boundary  = mtr_i & (phase_q >= last);

    assign bit_strobe_o = boundary;
    // Gating with mode keeps a bit latched before a switch to write mode
    // from leaking out.
    assign bit_value_o  = pending_q & mode_i;

    always_comb begin
        phase_d   = phase_q;
        pending_d = pending_q;
        if (mtr_i) begin
            if (boundary) begin
                phase_d   = '0;
                pending_d = 1'b0;
            end else begin
                phase_d   = phase_q + 1'b1;
            end
            // Edge wins over the boundary reset: the boundary has already
            // consumed the old pending bit, the edge re-centres the cell.
            if (flux_edge) begin
                pending_d = 1'b1;
                phase_d   = half;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flux_d_q  <= 1'b0;
            phase_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            // Tracks flux even with the motor off, so re-enabling with
            // flux already high does not look like a transition.
            flux_d_q  <= flux_i;
            phase_q   <= phase_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/c1541_flux_decoder.sv
// c1541_flux_decoder
//   Read electronics of the 1541: recovers bits from the flux stream,
//   assembles bytes, detects SYNC and strobes BYTE READY.
//   Parameter:
//     BYTE_PULSE       BYTE READY low time in clk cycles (1..255)
//   Ports:
//     clk, reset       clock, async active-high reset
//     mtr              motor on; 0 holds all state and outputs
//     mode             1 = read, 0 = write (bit pacing only)
//     soe              byte-ready enable; 0 suppresses byte_n
//     speed_zone       density zone 0..3
//     flux             flux-change pulse
//     dout             last completed byte
//     sync_n           low while the last SYNC_BITS bits are all ones
//     byte_n           BYTE READY, active-low pulse
module c1541_flux_decoder
    import c1541_pkg::*;
#(
    parameter int BYTE_PULSE = 64
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mtr,
    input  logic       mode,
    input  logic       soe,
    input  logic [1:0] speed_zone,
    input  logic       flux,
    output logic [7:0] dout,
    output logic       sync_n,
    output logic       byte_n
);

    localparam logic [7:0] PULSE_LAST = 8'(BYTE_PULSE - 1);

    logic                 bit_strobe;
    logic                 bit_value;

    logic [SYNC_BITS-1:0] shift_q, shift_d;
    logic [2:0]           bitcnt_q, bitcnt_d;
    logic                 sync_n_q, sync_n_d;
    logic [7:0]           dout_q, dout_d;
    logic                 byte_n_q, byte_n_d;
    logic [7:0]           pulse_q, pulse_d;

    c1541_bit_clock u_bit_clock (
        .clk          (clk),
        .rst          (reset),
        .mtr_i        (mtr),
        .mode_i       (mode),
        .speed_zone_i (speed_zone),
        .flux_i       (flux),
        .bit_strobe_o (bit_strobe),
        .bit_value_o  (bit_value)
    );

    always_comb begin
        shift_d  = shift_q;
        bitcnt_d = bitcnt_q;
        sync_n_d = sync_n_q;
        dout_d   = dout_q;
        byte_n_d = byte_n_q;
        pulse_d  = pulse_q;
        if (mtr) begin
            if (!byte_n_q) begin
                if (pulse_q == 8'd0) byte_n_d = 1'b1;
                else                 pulse_d  = pulse_q - 8'd1;
            end
            if (bit_strobe) begin
                shift_d  = {shift_q[SYNC_BITS-2:0], bit_value};
                sync_n_d = ~(&shift_d & mode);
                // The new sync state is used: the first zero after a SYNC
                // mark is already bit 1 of the following byte.
                if (!sync_n_d) begin
                    bitcnt_d = 3'd0;
                end else begin
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        dout_d = shift_d[7:0];
                        // Retriggers a pulse that is still running.
                        if (soe) begin
                            byte_n_d = 1'b0;
                            pulse_d  = PULSE_LAST;
                        end
                    end
                end
            end else if (!mode) begin
                sync_n_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q  <= '0;
            bitcnt_q <= 3'd0;
            sync_n_q <= 1'b1;
            dout_q   <= 8'h00;
            byte_n_q <= 1'b1;
            pulse_q  <= 8'd0;
        end else begin
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            sync_n_q <= sync_n_d;
            dout_q   <= dout_d;
            byte_n_q <= byte_n_d;
            pulse_q  <= pulse_d;
        end
    end

    assign dout   = dout_q;
    assign sync_n = sync_n_q;
    assign byte_n = byte_n_q;

endmodule

// File: tb/tb_c1541_flux_decoder.sv
// tb_c1541_flux_decoder
//   Directed bench for c1541_flux_decoder: reset, SYNC + GCR byte in
//   zone 3, free-running zone 0 bytes with soe on/off, edge coincident
//   with a boundary, motor stop with flux held high, write mode pacing.
module tb_c1541_flux_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       mtr;
    logic       mode;
    logic       soe;
    logic [1:0] speed_zone;
    logic       flux;
    logic [7:0] dout;
    logic       sync_n;
    logic       byte_n;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int low_cnt = 0;

    c1541_flux_decoder #(.BYTE_PULSE(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .mtr        (mtr),
        .mode       (mode),
        .soe        (soe),
        .speed_zone (speed_zone),
        .flux       (flux),
        .dout       (dout),
        .sync_n     (sync_n),
        .byte_n     (byte_n)
    );

    always #5 clk = ~clk;

    // One clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (byte_n === 1'b0) low_cnt++;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One zone-3 bit cell (104 clocks); a '1' is a flux pulse at its start.
    task automatic send3(input logic b);
        if (b) flux = 1'b1;
        tick();
        flux = 1'b0;
        repeat (103) tick();
    endtask

    initial begin
        logic [7:0] d;
        reset = 1'b1; mtr = 1'b1; mode = 1'b1; soe = 1'b1;
        speed_zone = 2'd3; flux = 1'b0;
        tick(); tick();
        chk("rst_dout",   {24'd0, dout}, 32'h00);
        chk("rst_sync_n", {31'd0, sync_n}, 32'd1);
        chk("rst_byte_n", {31'd0, byte_n}, 32'd1);
        reset = 1'b0;

        // Zone 3 SYNC: ten ones, a byte of 0xFF completes on the 8th.
        for (int i = 1; i <= 10; i++) begin
            send3(1'b1);
            if (i == 8) chk("pre_dout_ff", {24'd0, dout}, 32'hFF);
            if (i == 9) chk("sync_n_9ones", {31'd0, sync_n}, 32'd1);
        end
        chk("sync_n_10ones", {31'd0, sync_n}, 32'd0);

        low_cnt = 0;
        d = 8'h52;
        for (int i = 7; i >= 0; i--) begin
            send3(d[i]);
            if (i == 7) chk("sync_n_first0", {31'd0, sync_n}, 32'd1);
        end
        chk("gcr_dout_52",   {24'd0, dout}, 32'h52);
        chk("gcr_byte_n_lo", {31'd0, byte_n}, 32'd0);
        send3(1'b0);
        chk("gcr_pulse_len", low_cnt, 32'd64);

        d = 8'h35;
        for (int i = 6; i >= 0; i--) send3(d[i]);
        chk("b2_dout_35",   {24'd0, dout}, 32'h35);
        chk("b2_byte_n_lo", {31'd0, byte_n}, 32'd0);

        // Asynchronous reset mid-pulse.
        reset = 1'b1;
        #1;
        chk("mid_rst_dout",   {24'd0, dout}, 32'h00);
        chk("mid_rst_byte_n", {31'd0, byte_n}, 32'd1);
        chk("mid_rst_sync_n", {31'd0, sync_n}, 32'd1);

        // Zone 0, no flux: boundaries every 128, byte every 1024.
        speed_zone = 2'd0;
        tick(); tick();
        reset = 1'b0;
        cyc = 0;
        low_cnt = 0;
        wait_to(1023);
        chk("z0_byte_n_1023", {31'd0, byte_n}, 32'd1);
        tick();
        chk("z0_byte_n_1024", {31'd0, byte_n}, 32'd0);
        chk("z0_dout_1024",   {24'd0, dout}, 32'h00);
        wait_to(1087);
        chk("z0_byte_n_1087", {31'd0, byte_n}, 32'd0);
        tick();
        chk("z0_byte_n_1088", {31'd0, byte_n}, 32'd1);
        soe = 1'b0;
        wait_to(2048);
        chk("soe0_dout",   {24'd0, dout}, 32'h00);
        chk("soe0_byte_n", {31'd0, byte_n}, 32'd1);
        wait_to(2100);
        chk("soe0_no_pulse", low_cnt, 32'd64);
        soe = 1'b1;

        // Edge on the boundary at 2176: 0 shifted, then 1 at 2240.
        wait_to(2175);
        flux = 1'b1;
        tick();
        flux = 1'b0;
        wait_to(3007);
        chk("coin_dout_pre",   {24'd0, dout}, 32'h00);
        chk("coin_byte_n_pre", {31'd0, byte_n}, 32'd1);
        tick();
        chk("coin_dout_40",    {24'd0, dout}, 32'h40);
        chk("coin_byte_n_lo",  {31'd0, byte_n}, 32'd0);

        // Motor off for 500 clocks mid-byte, flux rises and stays high.
        wait_to(3420);
        mtr = 1'b0;
        wait_to(3430);
        flux = 1'b1;
        wait_to(3920);
        mtr = 1'b1;
        wait_to(4531);
        chk("mtr_dout_pre",   {24'd0, dout}, 32'h40);
        chk("mtr_byte_n_pre", {31'd0, byte_n}, 32'd1);
        tick();
        chk("mtr_dout_00",    {24'd0, dout}, 32'h00);
        chk("mtr_byte_n_lo",  {31'd0, byte_n}, 32'd0);
        wait_to(4540);
        flux = 1'b0;

        // Eight ones in read mode, then write mode with flux every cell.
        for (int j = 0; j < 8; j++) begin
            wait_to(4595 + 128 * j);
            flux = 1'b1;
            tick();
            flux = 1'b0;
        end
        wait_to(5555);
        chk("rd_dout_pre", {24'd0, dout}, 32'h00);
        tick();
        chk("rd_dout_ff",   {24'd0, dout}, 32'hFF);
        chk("rd_byte_n_lo", {31'd0, byte_n}, 32'd0);
        chk("rd_sync_n",    {31'd0, sync_n}, 32'd1);
        mode = 1'b0;
        for (int j = 8; j < 24; j++) begin
            wait_to(4595 + 128 * j);
            flux = 1'b1;
            tick();
            flux = 1'b0;
            if (j == 11) chk("wr_sync_n_10", {31'd0, sync_n}, 32'd1);
            if (j == 15) begin
                wait_to(6579);
                chk("wr_dout_pre", {24'd0, dout}, 32'hFF);
                tick();
                chk("wr_dout_00",   {24'd0, dout}, 32'h00);
                chk("wr_byte_n_lo", {31'd0, byte_n}, 32'd0);
            end
        end
        wait_to(7603);
        chk("wr2_byte_n_pre", {31'd0, byte_n}, 32'd1);
        tick();
        chk("wr2_byte_n_lo", {31'd0, byte_n}, 32'd0);
        chk("wr2_dout",      {24'd0, dout}, 32'h00);
        chk("wr2_sync_n",    {31'd0, sync_n}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
